// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: controller states, the
// per-stage enable/flush bundle and its canned values.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERR      = 3'd4
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

  localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_MEMSTALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_BUBBLE   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_IDLE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // States in which the pipeline is live and memory stalls are honoured.
  function automatic logic is_active(input state_e st);
    return (st == RUN) || (st == MEM_WAIT) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard inputs from the datapath and stage enable/flush controls back to it.
interface hazard_sequencer_if #(parameter int CNT_W = 16);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;
  logic             resume;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_wb_flush;
  logic             halted;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken,
           mem_req, mem_ready, halt_req, resume,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_wb_flush, halted, mem_timeout_err,
           stall_count
  );

  modport master (
    output id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken,
           mem_req, mem_ready, halt_req, resume,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_wb_flush, halted, mem_timeout_err,
           stall_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_loaduse
);

  // x0 is never a real dependency
  assign o_loaduse = i_ex_memread && (i_ex_rd != 5'd0) &&
                     ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline controller: load-use stalls, branch flushes, data-memory waits with
// timeout trap, and debug halt with back-end drain.
module hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_sequencer_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              r_state;
  logic                r_ret_drain;
  logic [1:0]          r_drain_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_stall_count;

  state_e              w_state_nxt;
  logic                w_ret_drain_nxt;
  logic [1:0]          w_drain_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  pipe_ctrl_t          w_ctrl;
  logic                w_halted;
  logic                w_err;
  logic                w_loaduse;
  logic                w_memstall;
  logic                w_eff_drain;
  logic                w_stall_qual;

  load_use_detect u_lud (
    .i_id_rs1     (bus.id_rs1),
    .i_id_rs2     (bus.id_rs2),
    .i_ex_memread (bus.ex_memread),
    .i_ex_rd      (bus.ex_rd),
    .o_loaduse    (w_loaduse)
  );

  assign w_memstall   = bus.mem_req && !bus.mem_ready;
  // A released wait behaves exactly like the state it interrupted
  assign w_eff_drain  = (r_state == DRAIN) || ((r_state == MEM_WAIT) && r_ret_drain);
  assign w_stall_qual = is_active(r_state) && !w_ctrl.pc_en;

  // Next-state and stage-control decode, priority memstall > branch > loaduse > halt
  always_comb begin
    w_state_nxt     = r_state;
    w_ret_drain_nxt = r_ret_drain;
    w_drain_nxt     = r_drain_cnt;
    w_wait_nxt      = r_wait_cnt;
    w_ctrl          = CTRL_RUN;
    w_halted        = 1'b0;
    w_err           = 1'b0;
    case (r_state)
      RUN, MEM_WAIT, DRAIN: begin
        if (w_memstall) begin
          w_ctrl = CTRL_MEMSTALL;
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = MEM_WAIT;
            w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
            if (r_state != MEM_WAIT) begin
              w_ret_drain_nxt = (r_state == DRAIN);
            end else begin
              w_ret_drain_nxt = r_ret_drain;
            end
          end
        end else begin
          w_wait_nxt = '0;
          if (w_eff_drain) begin
            w_ctrl = CTRL_BUBBLE;
            w_drain_nxt = r_drain_cnt - 2'd1;
            if (r_drain_cnt == 2'd1) begin
              w_state_nxt = HALTED;
            end else begin
              w_state_nxt = DRAIN;
            end
          end else if (bus.ex_branch_taken) begin
            w_ctrl      = CTRL_BRANCH;
            w_state_nxt = RUN;
          end else if (w_loaduse) begin
            w_ctrl      = CTRL_BUBBLE;
            w_state_nxt = RUN;
          end else if (bus.halt_req) begin
            w_state_nxt = DRAIN;
            w_drain_nxt = DRAIN_CYCLES;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      HALTED: begin
        w_ctrl   = CTRL_IDLE;
        w_halted = 1'b1;
        if (bus.resume) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = HALTED;
        end
      end
      ERR: begin
        w_ctrl = CTRL_IDLE;
        w_err  = 1'b1;
      end
      default: begin
        w_ctrl      = CTRL_IDLE;
        w_state_nxt = ERR;
      end
    endcase
    // Reset overrides the decode immediately, before any clock edge
    if (!rst_n) begin
      w_ctrl   = CTRL_RESET;
      w_halted = 1'b0;
      w_err    = 1'b0;
    end else begin
      w_ctrl   = w_ctrl;
    end
  end

  // State, drain/wait counters and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_ret_drain   <= 1'b0;
      r_drain_cnt   <= 2'd0;
      r_wait_cnt    <= '0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_drain <= w_ret_drain_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_wait_cnt  <= w_wait_nxt;
      if (w_stall_qual && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en           = w_ctrl.pc_en;
  assign bus.if_id_en        = w_ctrl.if_id_en;
  assign bus.if_id_flush     = w_ctrl.if_id_flush;
  assign bus.id_ex_en        = w_ctrl.id_ex_en;
  assign bus.id_ex_flush     = w_ctrl.id_ex_flush;
  assign bus.ex_mem_en       = w_ctrl.ex_mem_en;
  assign bus.mem_wb_en       = w_ctrl.mem_wb_en;
  assign bus.mem_wb_flush    = w_ctrl.mem_wb_flush;
  assign bus.halted          = w_halted;
  assign bus.mem_timeout_err = w_err;
  assign bus.stall_count     = r_stall_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: per-cycle expectations queued with
// the stimulus and popped against the DUT outputs mid-cycle.
module tb_hazard_sequencer;

  localparam logic [7:0] E_RUN   = 8'b1101_0110;
  localparam logic [7:0] E_RST   = 8'b0010_1001;
  localparam logic [7:0] E_MEMST = 8'b0000_0011;
  localparam logic [7:0] E_BR    = 8'b1111_1110;
  localparam logic [7:0] E_BUB   = 8'b0001_1110;
  localparam logic [7:0] E_IDLE  = 8'b0000_0000;

  logic clk;
  logic rst_n;
  hazard_sequencer_if #(.CNT_W(16)) bus();

  hazard_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp;
  int            n_fail;
  logic [15:0]   exp_cnt;
  logic [25:0]   sb[$];
  logic [25:0]   e;
  logic [25:0]   o;

  function automatic logic [25:0] obs();
    return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
            bus.ex_mem_en, bus.mem_wb_en, bus.mem_wb_flush, bus.halted,
            bus.mem_timeout_err, bus.stall_count};
  endfunction

  task automatic set_idle();
    bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.ex_memread = 1'b0; bus.ex_rd = 5'd3;
    bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b1;
    bus.halt_req = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic push(input logic [7:0] c, input logic h, input logic er, input bit counts);
    sb.push_back({c, h, er, exp_cnt});
    if (counts && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      rst_n = (i == 3);
      exp_cnt = 16'd0;
      push((i == 3) ? E_RUN : E_RST, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  task automatic test_loaduse();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      case (i)
        0: begin bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; push(E_BUB, 1'b0, 1'b0, 1'b1); end
        2: begin bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; push(E_RUN, 1'b0, 1'b0, 1'b0); end
        4: begin bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; push(E_BUB, 1'b0, 1'b0, 1'b1); end
        5: begin bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; push(E_RUN, 1'b0, 1'b0, 1'b0); end
        default: push(E_RUN, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL loaduse cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  task automatic test_branch_over_loaduse();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      if (i == 0) begin
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.ex_branch_taken = 1'b1;
        push(E_BR, 1'b0, 1'b0, 1'b0);
      end else begin
        push(E_RUN, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL branch cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  task automatic test_memstall();
    for (int i = 0; i < 9; i++) begin
      set_idle();
      if (i < 4 || i == 6) begin
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_branch_taken = (i == 6);
        push(E_MEMST, 1'b0, 1'b0, 1'b1);
      end else if (i == 4) begin
        bus.mem_req = 1'b1;
        push(E_RUN, 1'b0, 1'b0, 1'b0);
      end else if (i == 7) begin
        bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
        push(E_BR, 1'b0, 1'b0, 1'b0);
      end else begin
        push(E_RUN, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL memstall cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 22; i++) begin
      set_idle();
      if (i < 16) begin
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        push(E_MEMST, 1'b0, 1'b0, 1'b1);
      end else if (i < 20) begin
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        bus.halt_req = 1'b1; bus.resume = i[0];
        push(E_IDLE, 1'b0, 1'b1, 1'b0);
      end else begin
        rst_n = (i == 21);
        exp_cnt = 16'd0;
        push((i == 21) ? E_RUN : E_RST, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL timeout cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  task automatic test_halt_resume();
    for (int i = 0; i < 9; i++) begin
      set_idle();
      case (i)
        0: begin bus.halt_req = 1'b1; push(E_RUN, 1'b0, 1'b0, 1'b0); end
        1, 2, 3: begin bus.halt_req = 1'b1; push(E_BUB, 1'b0, 1'b0, 1'b1); end
        4: begin bus.halt_req = 1'b1; push(E_IDLE, 1'b1, 1'b0, 1'b0); end
        5: push(E_IDLE, 1'b1, 1'b0, 1'b0);
        6: begin bus.resume = 1'b1; push(E_IDLE, 1'b1, 1'b0, 1'b0); end
        8: begin bus.resume = 1'b1; push(E_RUN, 1'b0, 1'b0, 1'b0); end
        default: push(E_RUN, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL halt cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  task automatic test_drain_memstall();
    for (int i = 0; i < 9; i++) begin
      set_idle();
      case (i)
        0: begin bus.halt_req = 1'b1; push(E_RUN, 1'b0, 1'b0, 1'b0); end
        1, 4, 5: begin bus.halt_req = 1'b1; push(E_BUB, 1'b0, 1'b0, 1'b1); end
        2, 3: begin bus.halt_req = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0; push(E_MEMST, 1'b0, 1'b0, 1'b1); end
        6: begin bus.halt_req = 1'b1; push(E_IDLE, 1'b1, 1'b0, 1'b0); end
        7: begin bus.resume = 1'b1; push(E_IDLE, 1'b1, 1'b0, 1'b0); end
        default: push(E_RUN, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL drain_mem cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      case (i)
        0: begin bus.halt_req = 1'b1; push(E_RUN, 1'b0, 1'b0, 1'b0); end
        1: begin bus.halt_req = 1'b1; push(E_BUB, 1'b0, 1'b0, 1'b1); end
        2: begin bus.halt_req = 1'b1; rst_n = 1'b0; exp_cnt = 16'd0; push(E_RST, 1'b0, 1'b0, 1'b0); end
        3: begin rst_n = 1'b1; push(E_RUN, 1'b0, 1'b0, 1'b0); end
        4: begin bus.mem_req = 1'b1; bus.mem_ready = 1'b0; push(E_MEMST, 1'b0, 1'b0, 1'b1); end
        default: push(E_RUN, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rst_drain cyc%0d got %h exp %h", i, o, e); end
      next_cycle();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    exp_cnt = 16'd0;
    rst_n   = 1'b0;
    set_idle();
    #1;
    test_reset();
    test_loaduse();
    test_branch_over_loaduse();
    test_memstall();
    test_halt_resume();
    test_drain_memstall();
    test_reset_mid_drain();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central pipeline controller for the 5-stage RV32 core.
- Generates the load-enable and flush (bubble) controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers.
- Sequences four kinds of events:
  - load-use stalls;
  - taken-branch/jump flushes;
  - multi-cycle data-memory waits, with a timeout;
  - debug halt/resume, which drains the back end cleanly.

Parameters:
- MEM_TIMEOUT, 15: consecutive data-memory wait cycles tolerated before the error trap.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- ex_memread  in  1  ID/EX MemRead of instruction in EX
- ex_rd  in  5  ID/EX rd of instruction in EX
- ex_branch_taken  in  1  branch/JAL in EX resolved taken (PC target valid)
- mem_req  in  1  EX/MEM MemRead|MemWrite asserted
- mem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  debug halt request, level, held until halted=1
- resume  in  1  single-cycle resume pulse
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP (wins over en)
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX load bubble (all control bits 0)
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_en  out  1  MEM/WB load enable
- mem_wb_flush  out  1  MEM/WB load bubble (RegWrite=0)
- halted  out  1  pipeline halted
- mem_timeout_err  out  1  sticky memory-timeout trap
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0 in RUN, MEM_WAIT or DRAIN

Behaviour:
- Reset asserted (any state, including mid-drain or mid-wait):
  - state=RUN; drain and timeout counters=0; stall_count=0.
  - Outputs forced: all *_en=0, all *_flush=1, halted=0, mem_timeout_err=0.
  - Release is synchronous to the next clk edge.
- Outputs are combinational from the registered state and the current inputs, giving zero-latency stalls.
- States: RUN, MEM_WAIT, DRAIN, HALTED, ERR.
- Default in RUN: all en=1, all flush=0.
- Per-cycle priority: memstall > branch > loaduse > halt acceptance.
- memstall = mem_req & !mem_ready, evaluated in RUN, MEM_WAIT and DRAIN:
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1 with mem_wb_flush=1, so no duplicate writeback.
  - State goes to MEM_WAIT and the wait counter increments.
  - When mem_ready=1, the counter clears and the state returns to the pre-wait state (RUN or DRAIN).
  - Wait counter == MEM_TIMEOUT with the stall still active -> ERR.
  - A taken branch held in EX during a stall is re-presented and flushed once the stall releases.
- branch (ex_branch_taken, no memstall):
  - pc_en=1, if_id_flush=1, id_ex_flush=1; EX/MEM and MEM/WB load normally.
  - Overrides a coincident load-use, because the ID instruction is wrong-path.
- loaduse (ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2)):
  - pc_en=0, if_id_en=0, id_ex_flush=1; downstream enabled.
  - Lasts exactly 1 cycle; no state change.
- Halt acceptance: in RUN, halt_req=1 and none of the above this cycle -> DRAIN with drain counter=3.
- DRAIN:
  - pc_en=0, if_id_en=0 (the ID instruction is preserved), id_ex_flush=1; EX/MEM and MEM/WB enabled.
  - Counter decrements per non-stalled cycle; at 0 -> HALTED.
  - Branch and load-use cannot arise, because bubbles occupy EX from the 2nd cycle on.
- HALTED:
  - All en=0, flush=0, halted=1.
  - resume=1 -> RUN next cycle. If halt_req is still high, RUN re-accepts it on the next eligible cycle.
  - resume outside HALTED is ignored.
- ERR:
  - All en=0, flush=0, mem_timeout_err=1.
  - Sticky; exits only via reset. halt_req and resume are ignored.
- stall_count: +1 on each qualifying cycle, saturates at 2^CNT_W-1.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, DRAIN, HALTED, ERR);
  - packed struct pipe_ctrl_t {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush};
  - localparam DRAIN_CYCLES=3.
- One combinational sub-module, load_use_detect (id_rs1, id_rs2, ex_memread, ex_rd -> loaduse).

Test Plan:
- Reset held 3 cycles, then release with idle inputs -> during reset all en=0 and flush=1; first cycle after release all en=1, flush=0, stall_count=0.
- ex_memread=1, ex_rd=5, id_rs2=5 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only; stall_count=1. Repeat with ex_rd=0 -> no stall.
- Same cycle: load-use match plus ex_branch_taken=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1; stall_count unchanged.
- mem_req=1, mem_ready=0 for 4 cycles, then ready -> 4 frozen cycles with mem_wb_flush=1, state back to RUN, stall_count=4. Hold ready low 16 cycles -> mem_timeout_err=1, persisting until rst_n=0.
- halt_req=1 in clean RUN -> 3 DRAIN cycles, then halted=1 with all en=0. resume pulse -> RUN next cycle, and the IF/ID instruction advances unchanged.
- halt_req during a 2-cycle memstall inside DRAIN -> drain counter pauses; halted rises after 3+2 cycles. rst_n low mid-DRAIN -> RUN, counters cleared.
